// File: rtl/prf_read_arbiter.sv
// Purpose: per-bank arbitration of PRF read requesters onto one read port per bank, then response steering.
// Latency: grant and bank enable are combinational in cycle N; resp_valid/resp_data appear in cycle N+1.
// Backpressure: a requester holds req_valid/req_pr until req_ready; losers simply retry next cycle.
// Option: define PRF_READ_ARB_RR_EN for round-robin per bank; otherwise fixed priority (lowest index wins).
module prf_read_arbiter #(
    parameter int PRF_RR_COUNT       = 9,
    parameter int PRF_BANK_COUNT     = 4,
    parameter int PR_COUNT           = 128,
    parameter int XLEN               = 32,
    parameter int LOG_PR_COUNT       = $clog2(PR_COUNT),
    parameter int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
    parameter int RID_W              = $clog2(PRF_RR_COUNT)
) (
    input  logic                                                            CLK,
    input  logic                                                            nRST,
    input  logic [PRF_RR_COUNT-1:0]                                         req_valid,
    input  logic [PRF_RR_COUNT-1:0][LOG_PR_COUNT-1:0]                       req_pr,
    output logic [PRF_RR_COUNT-1:0]                                         req_ready,
    output logic [PRF_BANK_COUNT-1:0]                                       bank_read_valid,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0]  bank_read_index,
    input  logic [PRF_BANK_COUNT-1:0][XLEN-1:0]                             bank_read_data,
    output logic [PRF_RR_COUNT-1:0]                                         resp_valid,
    output logic [PRF_RR_COUNT-1:0][XLEN-1:0]                               resp_data
);

    // Which requesters are valid and target each bank (bank = low PR bits)
    logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0] bank_hit;
    // Winning requester per bank this cycle
    logic [PRF_BANK_COUNT-1:0][RID_W-1:0]        winner;
    // Where each bank's search begins
    logic [PRF_BANK_COUNT-1:0][RID_W-1:0]        search_start;
    // Port ownership of the read that returns next cycle
    logic [PRF_BANK_COUNT-1:0]                   own_valid;
    logic [PRF_BANK_COUNT-1:0][RID_W-1:0]        own_id;
    int                                          idx;

`ifdef PRF_READ_ARB_RR_EN
    logic [PRF_BANK_COUNT-1:0][RID_W-1:0]        rr_ptr;

    assign search_start = rr_ptr;

    // Advance a bank's pointer past its winner, wrapping after the last requester; hold when idle
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr <= '0;
        end else begin
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                if (bank_read_valid[b]) begin
                    rr_ptr[b] <= (winner[b] == RID_W'(PRF_RR_COUNT - 1)) ? '0 : winner[b] + RID_W'(1);
                end
            end
        end
    end
`else
    // Fixed priority is a round-robin search that always starts at requester 0
    assign search_start = '0;
`endif

    // Decode each requester's target bank
    always_comb begin
        bank_hit = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int i = 0; i < PRF_RR_COUNT; i++) begin
                bank_hit[b][i] = req_valid[i] &&
                    (req_pr[i][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
            end
        end
    end

    // Per bank: first hit scanning from search_start, wrapping modulo the requester count
    always_comb begin
        req_ready       = '0;
        bank_read_valid = '0;
        bank_read_index = '0;
        winner          = '0;
        idx             = 0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int k = 0; k < PRF_RR_COUNT; k++) begin
                idx = int'(search_start[b]) + k;
                if (idx >= PRF_RR_COUNT) begin
                    idx = idx - PRF_RR_COUNT;
                end
                if (!bank_read_valid[b] && bank_hit[b][idx]) begin
                    bank_read_valid[b] = 1'b1;
                    winner[b]          = RID_W'(idx);
                    req_ready[idx]     = 1'b1;
                    bank_read_index[b] = req_pr[idx][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
                end
            end
        end
    end

    // Remember who owns each bank port; resp_valid is last cycle's grant vector since
    // each requester targets exactly one bank and so wins on at most one
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            own_valid  <= '0;
            own_id     <= '0;
            resp_valid <= '0;
        end else begin
            own_valid  <= bank_read_valid;
            own_id     <= winner;
            resp_valid <= req_ready;
        end
    end

    // Steer returning bank data to the owning requester; zero when nothing is owed
    always_comb begin
        resp_data = '0;
        for (int i = 0; i < PRF_RR_COUNT; i++) begin
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                if (own_valid[b] && (own_id[b] == RID_W'(i))) begin
                    resp_data[i] = bank_read_data[b];
                end
            end
        end
    end

endmodule

// File: tb/tb_prf_read_arbiter.sv
// Directed bench for prf_read_arbiter: vector table plus contention, reset and pipelining sequences.
// Bank RAM stub returns 32'hC0DE0000 | PR one cycle after each bank enable.
// Expectations for contention depend on whether PRF_READ_ARB_RR_EN is defined.
module tb_prf_read_arbiter;

    localparam bit RR =
`ifdef PRF_READ_ARB_RR_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        logic [8:0]       valid;
        logic [8:0][6:0]  pr;
        logic [8:0]       exp_ready;
        logic [3:0]       exp_bvalid;
        logic [3:0][4:0]  exp_index;
    } vec_t;

    logic                CLK;
    logic                nRST;
    logic [8:0]          req_valid;
    logic [8:0][6:0]     req_pr;
    logic [8:0]          req_ready;
    logic [3:0]          bank_read_valid;
    logic [3:0][4:0]     bank_read_index;
    logic [3:0][31:0]    bank_read_data;
    logic [8:0]          resp_valid;
    logic [8:0][31:0]    resp_data;

    int                  checks = 0;
    int                  errors = 0;
    logic [8:0]          exp_rv_q;
    logic [8:0][6:0]     exp_pr_q;
    vec_t                tbl[9];

    prf_read_arbiter dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .req_valid       (req_valid),
        .req_pr          (req_pr),
        .req_ready       (req_ready),
        .bank_read_valid (bank_read_valid),
        .bank_read_index (bank_read_index),
        .bank_read_data  (bank_read_data),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Bank RAM stub: one-cycle read latency, content derived from the PR number
    always @(posedge CLK) begin
        for (int b = 0; b < 4; b++) begin
            if (bank_read_valid[b]) begin
                bank_read_data[b] <= 32'hC0DE_0000 | 32'({bank_read_index[b], 2'(b)});
            end
        end
    end

    function automatic logic [62:0] pr1(input int i, input logic [6:0] p);
        return 63'(p) << (7 * i);
    endfunction

    function automatic vec_t mk(input logic [8:0] v, input logic [62:0] prs, input logic [8:0] rdy,
                                input logic [3:0] bv, input logic [19:0] idx);
        vec_t r;
        r.valid      = v;
        r.pr         = prs;
        r.exp_ready  = rdy;
        r.exp_bvalid = bv;
        r.exp_index  = idx;
        return r;
    endfunction

    // Every active requester reads PR 8 (bank 0, row 2)
    function automatic vec_t cont(input logic [8:0] v, input logic [8:0] rdy);
        vec_t r;
        r.valid      = v;
        r.pr         = {9{7'd8}};
        r.exp_ready  = rdy;
        r.exp_bvalid = (v != 9'd0) ? 4'h1 : 4'h0;
        r.exp_index  = (v != 9'd0) ? 20'd2 : 20'd0;
        return r;
    endfunction

    function automatic logic [287:0] exp_data(input logic [8:0] v, input logic [8:0][6:0] p);
        logic [8:0][31:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            if (v[i]) r[i] = 32'hC0DE_0000 | 32'(p[i]);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of requests, check grants now and last cycle's responses
    task automatic apply(input vec_t t, input string name);
        @(negedge CLK);
        req_valid = t.valid;
        req_pr    = t.pr;
        #1;
        chk({name, " ready"},      288'(req_ready),       288'(t.exp_ready));
        chk({name, " bank_valid"}, 288'(bank_read_valid), 288'(t.exp_bvalid));
        chk({name, " bank_index"}, 288'(bank_read_index), 288'(t.exp_index));
        chk({name, " resp_valid"}, 288'(resp_valid),      288'(exp_rv_q));
        chk({name, " resp_data"},  resp_data,             exp_data(exp_rv_q, exp_pr_q));
        exp_rv_q = t.exp_ready;
        exp_pr_q = t.pr;
    endtask

    // Hold reset with random traffic; outputs of the response path must stay zero
    task automatic do_reset();
        nRST = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            req_valid = 9'($urandom);
            req_pr    = 63'({$urandom, $urandom});
            #1;
            chk("reset resp_valid", 288'(resp_valid), 288'(0));
            chk("reset resp_data",  resp_data,        288'(0));
        end
        @(negedge CLK);
        req_valid = '0;
        nRST      = 1'b1;
        exp_rv_q  = '0;
        exp_pr_q  = '0;
    endtask

    initial begin
        nRST      = 1'b0;
        req_valid = '0;
        req_pr    = '0;
        exp_rv_q  = '0;
        exp_pr_q  = '0;

        tbl[0] = mk(9'h000, 63'd0, 9'h000, 4'h0, 20'd0);
        tbl[1] = mk(9'h0A5, pr1(0, 7'd4) | pr1(2, 7'd9) | pr1(5, 7'd14) | pr1(7, 7'd19),
                    9'h0A5, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1});
        tbl[2] = mk(9'h000, 63'd0, 9'h000, 4'h0, 20'd0);
        tbl[3] = mk(9'h008, pr1(3, 7'd1), 9'h008, 4'h2, {5'd0, 5'd0, 5'd0, 5'd0});
        tbl[4] = mk(9'h008, pr1(3, 7'd5), 9'h008, 4'h2, {5'd0, 5'd0, 5'd1, 5'd0});
        tbl[5] = mk(9'h008, pr1(3, 7'd9), 9'h008, 4'h2, {5'd0, 5'd0, 5'd2, 5'd0});
        tbl[6] = mk(9'h140, pr1(8, 7'd127) | pr1(6, 7'd0), 9'h140, 4'h9, {5'd31, 5'd0, 5'd0, 5'd0});
        tbl[7] = mk(9'h0B0, pr1(4, 7'd3) | pr1(5, 7'd6) | pr1(7, 7'd125),
                    9'h0B0, 4'hE, {5'd0, 5'd1, 5'd31, 5'd0});
        tbl[8] = mk(9'h000, 63'd0, 9'h000, 4'h0, 20'd0);

        // Reset with random requests, then requester 0 wins the first contended bank
        do_reset();
        apply(cont(9'h049, 9'h001), "post_reset_contend");

        // Table: non-conflicting reads, back-to-back on one requester, edge PRs
        for (int k = 0; k < 9; k++) begin
            apply(tbl[k], $sformatf("vec%0d", k));
        end

        // Contention on PR 8 from a clean pointer state
        do_reset();
        apply(cont(9'h112, 9'h002), "cont_1of3");
        apply(cont(9'h110, 9'h010), "cont_4of2");
        apply(cont(9'h100, 9'h100), "cont_8");
        apply(cont(9'h102, 9'h002), "cont_again_1");
        apply(cont(9'h100, 9'h100), "cont_again_8");
        // Requesters 1 and 4 hold valid continuously
        apply(cont(9'h012, 9'h002), "hold_a");
        apply(cont(9'h012, RR ? 9'h010 : 9'h002), "hold_b");
        apply(cont(9'h012, 9'h002), "hold_c");
        apply(cont(9'h012, RR ? 9'h010 : 9'h002), "hold_d");
        apply(cont(9'h010, 9'h010), "hold_drop1");
        // Requesters 0 and 8: round-robin picks 8 then wraps to 0
        apply(cont(9'h101, RR ? 9'h100 : 9'h001), "wrap_a");
        apply(cont(9'h101, 9'h001), "wrap_b");
        apply(cont(9'h000, 9'h000), "cont_idle");

        // Reset asserted right after a grant: its response must never appear
        apply(mk(9'h004, pr1(2, 7'd6), 9'h004, 4'h4, {5'd0, 5'd1, 5'd0, 5'd0}), "pre_midrst");
        @(posedge CLK);
        #1;
        nRST      = 1'b0;
        req_valid = '0;
        #1;
        chk("midrst resp_valid", 288'(resp_valid), 288'(0));
        chk("midrst resp_data",  resp_data,        288'(0));
        @(negedge CLK);
        chk("midrst hold resp_valid", 288'(resp_valid), 288'(0));
        nRST     = 1'b1;
        exp_rv_q = '0;
        exp_pr_q = '0;
        apply(cont(9'h000, 9'h000), "post_midrst");
        apply(cont(9'h000, 9'h000), "post_midrst2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prf_read_arbiter.md
# prf_read_arbiter

Arbitrates the PRF read requesters (ALU Reg-Reg/MDU A/B, ALU Reg-Imm A, BRU A/B, LDU A, STAMOFU A/B, SYS A) onto the banked physical register file, which has one read port per bank. Each cycle, each bank grants at most one requester whose physical register maps to that bank. The block issues the bank read, tracks which requester owns each bank port, and steers the returning bank data to the winning requester one cycle later. It sits between the issue-queue read stage and the PRF bank RAMs.

## Interface
- PRF_RR_COUNT, 9, number of read requesters
- PRF_BANK_COUNT, 4, number of PRF banks (power of 2)
- PR_COUNT, 128, physical registers
- XLEN, 32, data width
- Derived: LOG_PR_COUNT = 7, LOG_PRF_BANK_COUNT = 2, RID_W = $clog2(PRF_RR_COUNT) = 4

Ports:
- CLK  in  1  clock; single clock domain
- nRST  in  1  asynchronous, active-low reset
- req_valid  in  [PRF_RR_COUNT]  requester has a pending read
- req_pr  in  [PRF_RR_COUNT][LOG_PR_COUNT]  physical register to read
- req_ready  out  [PRF_RR_COUNT]  grant this cycle (combinational)
- bank_read_valid  out  [PRF_BANK_COUNT]  bank read-port enable
- bank_read_index  out  [PRF_BANK_COUNT][LOG_PR_COUNT-LOG_PRF_BANK_COUNT]  row within the bank
- bank_read_data  in  [PRF_BANK_COUNT][XLEN]  bank RAM output, valid one cycle after the enable
- resp_valid  out  [PRF_RR_COUNT]  read data available (registered)
- resp_data  out  [PRF_RR_COUNT][XLEN]  read data

## Operation
- Bank selection: bank = req_pr[LOG_PRF_BANK_COUNT-1:0]. Row index = req_pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT].
- Per-bank arbiter: among the valid requesters that target bank b, grant exactly one.
  - The search starts at rr_ptr[b] and wraps modulo PRF_RR_COUNT.
  - Requesters that target other banks are ignored.
- Grant assertions:
  - req_ready[i] = 1 only for the winner of its bank.
  - bank_read_valid[b] = 1 when any requester targets bank b.
  - bank_read_index[b] = the winner's row.
- Pointer update: on a grant at bank b, rr_ptr[b] <= winner+1. If winner = PRF_RR_COUNT-1, it wraps to 0. With no grant, rr_ptr[b] holds.
- Up to PRF_BANK_COUNT grants per cycle, one per bank. Requesters to distinct banks never block each other.
- Handshake:
  - A requester holds req_valid and keeps req_pr stable until req_ready.
  - A request is consumed in the cycle where req_valid & req_ready.
  - req_ready does not depend on any requester's resp path.
- Tracking registers, updated each cycle:
  - own_valid[b] <= bank_read_valid[b]
  - own_id[b] <= winner index
- Response steering (registered valid, combinational data):
  - resp_valid[i] <= OR over b of (bank_read_valid[b] & winner[b]==i). At most one bank can match, since each requester targets one bank.
  - resp_data[i] = bank_read_data[b] for the bank b with own_valid[b] & own_id[b]==i. Otherwise resp_data[i] = 0.
- Two requesters reading the same PR are serialized: one grant per cycle, in round-robin order. No merging.

## Timing
- Reset values (async, nRST low): rr_ptr[*] = 0, own_valid = 0, own_id = 0, resp_valid = 0, so resp_data = 0.
- Combinational outputs follow the inputs; with no valid requests they are 0.
- Latency:
  - Request granted in cycle N.
  - Bank enable in cycle N.
  - resp_valid and resp_data in cycle N+1.
  - Fully pipelined: a new grant per bank every cycle.
- Reset mid-operation: in-flight reads are dropped, and resp_valid = 0 from the reset assertion onward. The first cycle after release arbitrates from pointer 0.
- Requester 8 granted: the next search starts at requester 0 (wrap-around).

## Configuration
- PRF_READ_ARB_RR_EN defined: round-robin behaviour as described above.
- PRF_READ_ARB_RR_EN undefined:
  - rr_ptr registers are removed.
  - Each bank uses fixed priority: the lowest requester index wins.
  - Everything else is unchanged (latency, steering, resets).

## Test plan
- Reset: hold nRST = 0 with random requests. Required: resp_valid = 0, resp_data = 0. After release, requester 0 wins first on any contended bank.
- Four non-conflicting requests: req 0/2/5/7 read PR 4/9/14/19 (banks 0/1/2/3). Required in cycle N: all four ready, bank rows 1/2/3/4. Required in N+1: each resp_data equals the matching bank_read_data, resp_valid = 0x0A5.
- Contention with RR_EN: requesters 1, 4 and 8 all hold PR 8 (bank 0). Required: grants in order 1, 4, 8, one per cycle, with rr_ptr[0] going 2 → 5 → 0. Two more reads from 1 and 8 then grant 1 before 8.
- Same contention with RR_EN undefined: requesters 1 and 4 hold valid continuously. Required: 1 is always granted and 4 starves until 1 drops.
- Back-to-back pipelining: requester 3 reads PR 1, 5, 9 on consecutive cycles. Required: resp_valid[3] high for 3 consecutive cycles, with data in order.
- Reset mid-flight: assert nRST in the cycle after a grant. Required: no resp_valid is produced for that grant.
